// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request-side arbiter.
// Command register bit positions and the arbiter state encoding.
package dma_pkg;

   localparam int NCH = 4;

   localparam int CMD_DISABLE   = 2;
   localparam int CMD_ROTATE    = 4;
   localparam int CMD_DREQ_LOW  = 6;
   localparam int CMD_DACK_HIGH = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      SERVICE = 2'd2
   } state_e;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/dma_rot_prio_enc.sv
// Four-way priority encoder; in rotating mode the search starts
// just after the channel serviced last.
module dma_rot_prio_enc (
   input  logic [3:0] req,
   input  logic [1:0] lowPri,
   input  logic       rotate,
   output logic [1:0] winner,
   output logic       any
);

   logic [1:0] start;
   logic [1:0] idx;
   logic       found;

   assign start = rotate ? lowPri + 2'd1 : 2'd0;
   assign any   = |req;

   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      idx    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = start + 2'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request arbitration: samples DREQ, picks one channel, hands it
// to timing control and drives DACK for the length of the service.
module dma_priority_arbiter
   import dma_pkg::*;
#(
   parameter int NCH = dma_pkg::NCH
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [NCH-1:0] DREQ,
   input  logic [7:0]     commandReg,
   input  logic [NCH-1:0] maskReg,
   input  logic [NCH-1:0] requestReg,
   input  logic           svcStart,
   input  logic           svcDone,
   output logic [NCH-1:0] VALID_DREQ,
   output logic [NCH-1:0] DACK,
   output logic [1:0]     activeCh,
   output logic [NCH-1:0] clrReq
);

   state_e         state_q, state_d;
   logic [NCH-1:0] dreq_q;
   logic [1:0]     grant_q, grant_d;
   logic [1:0]     low_pri_q, low_pri_d;
   logic [NCH-1:0] valid_q, valid_d;
   logic [NCH-1:0] dack_q, dack_d;
   logic [NCH-1:0] clr_q, clr_d;
   logic           dack_act_q, dack_act_d;

   logic [NCH-1:0] eff_req;
   logic [1:0]     winner;
   logic           any;
   logic           disable_c;
   logic           dack_high;
   logic           unused_cmd;

   assign disable_c  = commandReg[CMD_DISABLE];
   assign dack_high  = commandReg[CMD_DACK_HIGH];
   assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

   // software requests bypass the mask; disable kills everything
   assign eff_req = disable_c ? '0
                  : ((dreq_q & ~maskReg) | requestReg);

   dma_rot_prio_enc u_enc (
      .req    (eff_req),
      .lowPri (low_pri_q),
      .rotate (commandReg[CMD_ROTATE]),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (any) state_d = GRANT;
         end
         GRANT: begin
            if (svcStart)
               state_d = SERVICE;
            else if (!eff_req[grant_q] || disable_c)
               state_d = IDLE;
         end
         SERVICE: begin
            if (svcDone) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d    = grant_q;
      valid_d    = valid_q;
      dack_act_d = dack_act_q;
      low_pri_d  = low_pri_q;
      clr_d      = '0;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               grant_d = winner;
               valid_d = onehot(winner);
            end
         end
         GRANT: begin
            if (svcStart)
               dack_act_d = 1'b1;
            else if (state_d == IDLE)
               valid_d = '0;
         end
         SERVICE: begin
            if (svcDone) begin
               valid_d    = '0;
               dack_act_d = 1'b0;
               low_pri_d  = grant_q;
               clr_d      = onehot(grant_q);
            end
         end
         default: begin
            valid_d    = '0;
            dack_act_d = 1'b0;
         end
      endcase
      if (dack_act_d)
         dack_d = dack_high ? onehot(grant_d) : ~onehot(grant_d);
      else
         dack_d = {NCH{~dack_high}};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         dreq_q     <= '0;
         grant_q    <= 2'd0;
         low_pri_q  <= 2'd3;
         valid_q    <= '0;
         dack_act_q <= 1'b0;
         dack_q     <= {NCH{~dack_high}};
         clr_q      <= '0;
      end else begin
         dreq_q     <= DREQ ^ {NCH{commandReg[CMD_DREQ_LOW]}};
         grant_q    <= grant_d;
         low_pri_q  <= low_pri_d;
         valid_q    <= valid_d;
         dack_act_q <= dack_act_d;
         dack_q     <= dack_d;
         clr_q      <= clr_d;
      end
   end

   assign VALID_DREQ = valid_q;
   assign DACK       = dack_q;
   assign clrReq     = clr_q;
   assign activeCh   = (state_q == IDLE) ? 2'd0 : grant_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed and random checks of the DMA arbiter against a
// transaction-level model of request, grant and service.
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] DREQ;
   logic [7:0] commandReg;
   logic [3:0] maskReg;
   logic [3:0] requestReg;
   logic       svcStart;
   logic       svcDone;
   logic [3:0] VALID_DREQ;
   logic [3:0] DACK;
   logic [1:0] activeCh;
   logic [3:0] clrReq;

   int n_checks = 0;
   int n_errors = 0;

   // model: phase 0 = nothing offered, 1 = offered, 2 = in service
   int       m_phase = 0;
   int       m_ch = 0;
   int       m_last = 3;
   bit [3:0] m_seen = 0;
   bit [3:0] m_valid = 0;
   bit [3:0] m_dack = 4'hF;
   bit [3:0] m_clr = 0;
   bit       m_ack_on = 0;

   always #5 CLK = ~CLK;

   dma_priority_arbiter dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DREQ       (DREQ),
      .commandReg (commandReg),
      .maskReg    (maskReg),
      .requestReg (requestReg),
      .svcStart   (svcStart),
      .svcDone    (svcDone),
      .VALID_DREQ (VALID_DREQ),
      .DACK       (DACK),
      .activeCh   (activeCh),
      .clrReq     (clrReq)
   );

   task automatic check(input string tag, input logic [3:0] got,
                        input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int pick(bit [3:0] req, bit rot, int last);
      int c;
      for (int k = 0; k < 4; k++) begin
         c = rot ? (last + 1 + k) % 4 : k;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      bit       rst = RESET;
      bit [7:0] cmd = commandReg;
      bit [3:0] pins = DREQ;
      bit [3:0] msk = maskReg;
      bit [3:0] sw = requestReg;
      bit       ss = svcStart;
      bit       sd = svcDone;
      bit [3:0] want;
      bit [3:0] oh;
      int       w;
      @(posedge CLK);
      if (rst) begin
         m_phase  = 0;
         m_valid  = 0;
         m_ack_on = 0;
         m_clr    = 0;
         m_last   = 3;
         m_seen   = 0;
      end else begin
         want  = cmd[2] ? 4'b0 : ((m_seen & ~msk) | sw);
         m_clr = 0;
         if (m_phase == 0) begin
            w = pick(want, cmd[4], m_last);
            if (w >= 0) begin
               m_ch    = w;
               m_phase = 1;
               m_valid = 4'(1 << w);
            end
         end else if (m_phase == 1) begin
            if (ss) begin
               m_phase  = 2;
               m_ack_on = 1;
            end else if (!want[m_ch]) begin
               m_phase = 0;
               m_valid = 0;
            end
         end else if (sd) begin
            m_phase  = 0;
            m_valid  = 0;
            m_ack_on = 0;
            m_last   = m_ch;
            m_clr    = 4'(1 << m_ch);
         end
         m_seen = pins ^ {4{cmd[6]}};
      end
      oh = 4'(1 << m_ch);
      if (m_ack_on) m_dack = cmd[7] ? oh : ~oh;
      else          m_dack = {4{~cmd[7]}};
      #1;
      check("valid", VALID_DREQ, m_valid);
      check("dack", DACK, m_dack);
      check("ch", {2'b00, activeCh}, 4'(m_phase != 0 ? m_ch : 0));
      check("clr", clrReq, m_clr);
      requestReg = requestReg & ~m_clr;
   endtask

   task automatic service();
      svcStart = 1'b1;
      tick();
      svcStart = 1'b0;
      tick();
      svcDone = 1'b1;
      tick();
      svcDone = 1'b0;
   endtask

   initial begin
      RESET      = 1'b1;
      DREQ       = 4'h0;
      commandReg = 8'h00;
      maskReg    = 4'h0;
      requestReg = 4'h0;
      svcStart   = 1'b0;
      svcDone    = 1'b0;
      tick();
      tick();
      check("rst_valid", VALID_DREQ, 4'b0000);
      check("rst_dack", DACK, 4'b1111);
      check("rst_ch", {2'b00, activeCh}, 4'b0000);
      check("rst_clr", clrReq, 4'b0000);
      RESET = 1'b0;

      // fixed priority
      DREQ = 4'b1010;
      tick();
      tick();
      check("fix_grant1", VALID_DREQ, 4'b0010);
      svcStart = 1'b1;
      tick();
      svcStart = 1'b0;
      check("fix_dack1", DACK, 4'b1101);
      DREQ = 4'b1000;
      tick();
      svcDone = 1'b1;
      tick();
      svcDone = 1'b0;
      check("fix_clr1", clrReq, 4'b0010);
      tick();
      check("fix_grant3", VALID_DREQ, 4'b1000);
      DREQ = 4'b0000;
      service();
      tick();
      tick();

      // rotating priority
      commandReg = 8'h10;
      DREQ = 4'b0010;
      tick();
      tick();
      check("rot_g1", VALID_DREQ, 4'b0010);
      DREQ = 4'b1111;
      service();
      tick();
      check("rot_g2", VALID_DREQ, 4'b0100);
      service();
      tick();
      check("rot_g3", VALID_DREQ, 4'b1000);
      service();
      tick();
      check("rot_g0", VALID_DREQ, 4'b0001);
      DREQ = 4'b0000;
      service();
      tick();
      tick();

      // mask and software request
      commandReg = 8'h00;
      maskReg = 4'b0001;
      DREQ = 4'b0001;
      tick();
      tick();
      tick();
      check("mask_none", VALID_DREQ, 4'b0000);
      requestReg = 4'b0001;
      tick();
      check("sw_grant", VALID_DREQ, 4'b0001);
      svcStart = 1'b1;
      tick();
      svcStart = 1'b0;
      tick();
      svcDone = 1'b1;
      tick();
      svcDone = 1'b0;
      check("sw_clr", clrReq, 4'b0001);
      tick();
      check("sw_clr_off", clrReq, 4'b0000);
      check("sw_no_regrant", VALID_DREQ, 4'b0000);
      maskReg = 4'b0000;
      DREQ = 4'b0000;
      tick();

      // polarity, then reset in service
      commandReg = 8'hC0;
      RESET = 1'b1;
      tick();
      check("pol_rst_dack", DACK, 4'b0000);
      RESET = 1'b0;
      DREQ = 4'b1011;
      tick();
      tick();
      check("pol_grant", VALID_DREQ, 4'b0100);
      svcStart = 1'b1;
      tick();
      svcStart = 1'b0;
      check("pol_dack", DACK, 4'b0100);
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("rsvc_valid", VALID_DREQ, 4'b0000);
      check("rsvc_dack", DACK, 4'b0000);
      check("rsvc_clr", clrReq, 4'b0000);
      commandReg = 8'h50;
      DREQ = 4'b0000;
      tick();
      tick();
      check("rsvc_lowpri", VALID_DREQ, 4'b0001);

      // withdrawal, then disable during service
      DREQ = 4'b1111;
      tick();
      tick();
      check("wd_idle", VALID_DREQ, 4'b0000);
      DREQ = 4'b0000;
      tick();
      tick();
      check("wd_lowpri", VALID_DREQ, 4'b0001);
      svcStart = 1'b1;
      tick();
      svcStart = 1'b0;
      commandReg = 8'h54;
      tick();
      svcDone = 1'b1;
      tick();
      svcDone = 1'b0;
      check("dis_clr", clrReq, 4'b0001);
      tick();
      tick();
      check("dis_nogrant", VALID_DREQ, 4'b0000);
      commandReg = 8'h00;
      tick();
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         RESET = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) DREQ = 4'($urandom);
         if ($urandom_range(0, 39) == 0)
            commandReg = 8'($urandom) & 8'hD0
                       | (($urandom_range(0, 3) == 0) ? 8'h04 : 8'h00);
         if ($urandom_range(0, 19) == 0) maskReg = 4'($urandom);
         if ($urandom_range(0, 29) == 0)
            requestReg = requestReg | 4'(1 << $urandom_range(0, 3));
         svcStart = ($urandom_range(0, 3) == 0);
         svcDone  = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Request-side stage of the DMA controller, directly upstream of the timing-control FSM. It samples the four DREQ pins, applies sense polarity, mask and software-request registers, arbitrates with fixed or rotating priority, and hands one one-hot granted channel to the timing control on VALID_DREQ. It drives the DACK pins for the duration of a service and updates rotating priority when the service completes.

## Interface
Parameters:
- NCH, 4, number of channels; the block is only specified for 4.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- DREQ  in  4  raw channel request pins
- commandReg  in  8  bit2 = controller disable, bit4 = rotating priority, bit6 = DREQ active-low, bit7 = DACK active-high
- maskReg  in  4  1 = channel masked (hardware DREQ ignored)
- requestReg  in  4  software request bits; never masked
- svcStart  in  1  timing control entered its first active state (validDACK)
- svcDone  in  1  timing control finished service (S4 or EOP)
- VALID_DREQ  out  4  registered one-hot granted request, to timing control
- DACK  out  4  registered acknowledge pins, polarity per commandReg[7]
- activeCh  out  2  index of granted or serviced channel
- clrReq  out  4  one-cycle pulse clearing the serviced channel's requestReg bit

## Operation
- Sampling: dreqQ <= DREQ ^ {4{commandReg[6]}} every cycle (normalised to active-high).
- Effective request: effReq = commandReg[2] ? 0 : ((dreqQ & ~maskReg) | requestReg).
- Priority: fixed (commandReg[4]=0): ch0 highest, ch3 lowest. Rotating (commandReg[4]=1): order starts at lowPri+1 mod 4, wraps; lowPri reset value 3 (equals fixed order). Fixed mode ignores lowPri but it is still updated.
- FSM states: IDLE, GRANT, SERVICE.
- IDLE: if effReq != 0, register winner into grantCh, VALID_DREQ <= onehot(grantCh), go GRANT; else stay.
- GRANT: VALID_DREQ held. svcStart -> SERVICE, DACK active on grantCh. Else if effReq[grantCh]=0 (request withdrawn) or commandReg[2]=1 -> IDLE, VALID_DREQ cleared, lowPri unchanged. A higher-priority request arriving in GRANT does not preempt.
- SERVICE: VALID_DREQ and DACK held regardless of DREQ, mask or disable. svcDone -> IDLE, VALID_DREQ and DACK cleared, lowPri <= grantCh, clrReq[grantCh] pulsed for one cycle.
- DACK pin value: active level = commandReg[7]; inactive channels drive ~commandReg[7].
- activeCh = grantCh in GRANT/SERVICE, 0 in IDLE.

## Timing
- Reset (RESET high at edge): state IDLE, VALID_DREQ=0, dackAct=0 (DACK = {4{~commandReg[7]}}), activeCh=0, clrReq=0, lowPri=3, dreqQ=0. Applies mid-service: service abandoned, no clrReq.
- Latency DREQ pin -> VALID_DREQ: 2 edges (sample edge, grant edge).
- svcStart sampled at edge k -> DACK active after edge k.
- svcDone sampled at edge k -> DACK/VALID_DREQ inactive and clrReq high after edge k; clrReq low after edge k+1. Earliest next grant after edge k+1, using updated lowPri.
- svcStart and withdrawal in same GRANT cycle: svcStart wins.
- svcDone outside SERVICE: ignored. svcStart outside GRANT: ignored.
- Polarity change on commandReg[7] takes effect on DACK after next edge.

## Structure
- dma_pkg: state enum {IDLE, GRANT, SERVICE}, command bit index constants (CMD_DISABLE=2, CMD_ROTATE=4, CMD_DREQ_LOW=6, CMD_DACK_HIGH=7), NCH.
- Sub-module dma_rot_prio_enc: combinational, inputs req[3:0], lowPri[1:0], rotate; outputs winner[1:0], any. Instantiated once.

## Test plan
- Fixed priority: DREQ=4'b1010 (bit6=0) -> VALID_DREQ=4'b0010 two edges later; after svcStart/svcDone, ch3 granted next.
- Rotating: commandReg[4]=1, service ch1, then DREQ=4'b1111 -> grant ch2; service ch2 -> grant ch3; then ch0.
- Mask/software: maskReg=4'b0001, DREQ=4'b0001 -> no grant; requestReg=4'b0001 -> grant ch0, clrReq=4'b0001 one cycle after svcDone.
- Polarity: commandReg[6]=1, commandReg[7]=1, DREQ=4'b1011 -> grant ch2; DACK reset value 4'b0000, 4'b0100 after svcStart.
- Withdrawal/disable: drop DREQ in GRANT -> IDLE, VALID_DREQ=0, lowPri unchanged; set commandReg[2] in SERVICE -> service completes, no new grant afterwards.
- RESET asserted during SERVICE -> next cycle VALID_DREQ=0, DACK inactive, lowPri=3, no clrReq.
